// File: rtl/scan_seq_pkg.sv
// rtl/scan_seq_pkg.sv - shared types and sizes for the 4-bit scan sequencer
package scan_seq_pkg;

  localparam int NUM_CHAN = 16;
  localparam int SEL_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

endpackage

// File: rtl/scan_sequencer_4b_if.sv
// rtl/scan_sequencer_4b_if.sv - control/decoder bus of the scan sequencer
// SCAN_SEQ_ONESHOT_EN adds the oneshot request line.
interface scan_sequencer_4b_if #(
  parameter int DWELL_W = 8
);
  import scan_seq_pkg::*;

  logic                start;
  logic                stop;
  logic [NUM_CHAN-1:0] chan_mask;
  logic [DWELL_W-1:0]  dwell;
`ifdef SCAN_SEQ_ONESHOT_EN
  logic                oneshot;
`endif
  logic [SEL_W-1:0]    sel;
  logic                enable_n;
  logic                busy;
  logic                frame_done;
  logic                err;

  modport master (
`ifdef SCAN_SEQ_ONESHOT_EN
    output oneshot,
`endif
    output start, stop, chan_mask, dwell,
    input  sel, enable_n, busy, frame_done, err
  );

  modport slave (
`ifdef SCAN_SEQ_ONESHOT_EN
    input  oneshot,
`endif
    input  start, stop, chan_mask, dwell,
    output sel, enable_n, busy, frame_done, err
  );

endinterface

// File: rtl/next_chan_find.sv
// rtl/next_chan_find.sv - lowest set mask bit above cur, else lowest set bit with wrap=1
module next_chan_find
  import scan_seq_pkg::*;
(
  input  logic [NUM_CHAN-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    next,
  output logic                wrap
);

  logic [SEL_W-1:0] lowest;

  // Descending walk so the last hit written is the lowest qualifying index.
  always_comb begin
    next   = '0;
    lowest = '0;
    wrap   = 1'b1;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = SEL_W'(i);
        if (i > int'(cur)) begin
          next = SEL_W'(i);
          wrap = 1'b0;
        end
      end
    end
    if (wrap) begin
      next = lowest;
    end
  end

endmodule

// File: rtl/scan_sequencer_4b.sv
// rtl/scan_sequencer_4b.sv - blanked channel scan driver for a 4-to-16 decoder
// SCAN_SEQ_ONESHOT_EN: stop at frame wrap when oneshot was set with start.
module scan_sequencer_4b
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  scan_sequencer_4b_if.slave  bus
);

  localparam int BLK_W = $clog2(BLANK_CYCLES + 2);
  localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  state_t              state;
  logic [NUM_CHAN-1:0] mask_lat;
  logic [DWELL_W-1:0]  dwell_lat;
  logic                oneshot_lat;
  logic                oneshot_req;
  logic [CNT_W-1:0]    cnt;

  logic [SEL_W-1:0]    first_chan;
  logic                first_wrap_unused;
  logic [SEL_W-1:0]    next_chan;
  logic                next_wrap;

  logic [DWELL_W-1:0]  load_dwell;
  state_t              enter_state;
  logic                enter_en_n;
  logic [CNT_W-1:0]    enter_cnt;

  // cur=all-ones always wraps, giving the lowest set bit of the live mask.
  next_chan_find u_first (
    .mask (bus.chan_mask),
    .cur  ({SEL_W{1'b1}}),
    .next (first_chan),
    .wrap (first_wrap_unused)
  );

  next_chan_find u_next (
    .mask (mask_lat),
    .cur  (bus.sel),
    .next (next_chan),
    .wrap (next_wrap)
  );

`ifdef SCAN_SEQ_ONESHOT_EN
  assign oneshot_req = bus.oneshot;
`else
  assign oneshot_req = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] dwell_last(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : CNT_W'(d - DWELL_W'(1));
  endfunction

  // Entry point of a channel: blanking first unless it is configured away.
  always_comb begin
    load_dwell = (state == DWELL && !next_wrap) ? dwell_lat : bus.dwell;
    if (BLANK_CYCLES == 0) begin
      enter_state = DWELL;
      enter_en_n  = 1'b0;
      enter_cnt   = dwell_last(load_dwell);
    end else begin
      enter_state = BLANK;
      enter_en_n  = 1'b1;
      enter_cnt   = BLANK_LAST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mask_lat       <= '0;
      dwell_lat      <= '0;
      oneshot_lat    <= 1'b0;
      cnt            <= '0;
      bus.sel        <= '0;
      bus.enable_n   <= 1'b1;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
      if (state != IDLE && bus.stop) begin
        state        <= IDLE;
        bus.enable_n <= 1'b1;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              if (bus.chan_mask == '0) begin
                bus.err <= 1'b1;
              end else begin
                mask_lat     <= bus.chan_mask;
                dwell_lat    <= bus.dwell;
                oneshot_lat  <= oneshot_req;
                bus.sel      <= first_chan;
                bus.busy     <= 1'b1;
                state        <= enter_state;
                bus.enable_n <= enter_en_n;
                cnt          <= enter_cnt;
              end
            end
          end
          BLANK: begin
            if (cnt == '0) begin
              state        <= DWELL;
              bus.enable_n <= 1'b0;
              cnt          <= dwell_last(dwell_lat);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          DWELL: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (!next_wrap) begin
              bus.sel      <= next_chan;
              state        <= enter_state;
              bus.enable_n <= enter_en_n;
              cnt          <= enter_cnt;
            end else if (oneshot_lat) begin
              bus.frame_done <= 1'b1;
              state          <= IDLE;
              bus.enable_n   <= 1'b1;
              bus.busy       <= 1'b0;
            end else if (bus.chan_mask == '0) begin
              bus.err      <= 1'b1;
              state        <= IDLE;
              bus.enable_n <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              // New frame: mask and dwell are only sampled here and at start.
              mask_lat       <= bus.chan_mask;
              dwell_lat      <= bus.dwell;
              bus.sel        <= first_chan;
              bus.frame_done <= 1'b1;
              state          <= enter_state;
              bus.enable_n   <= enter_en_n;
              cnt            <= enter_cnt;
            end
          end
          default: begin
            state        <= IDLE;
            bus.enable_n <= 1'b1;
            bus.busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/scan_sequencer_4b.md
Name: scan_sequencer_4b

Overview:
Upstream driver for the 4-to-16 active-low-enable decoder. Walks a 4-bit channel select through the enabled channels of a 16-bit mask, in ascending order with wrap-around. Holds each channel active for a programmable dwell. Inserts blanking (enable_n high) between channels, so the decoder outputs never show two channels and never glitch during a select change.

Parameters:
DWELL_W, 8, width of dwell-count input and internal dwell counter
BLANK_CYCLES, 2, cycles of enable_n=1 before each channel's dwell; 0 = no blanking

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin scanning
stop  input  1  abort request; takes effect on the next clock edge
chan_mask  input  16  bit i set = channel i is scanned
dwell  input  DWELL_W  active cycles per channel; 0 is treated as 1
sel  output  4  channel index to the decoder select input
enable_n  output  1  active-low enable to the decoder
busy  output  1  high while not IDLE
frame_done  output  1  one-cycle pulse on wrap to a new frame
err  output  1  one-cycle pulse when start or a wrap sees a zero mask

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values: sel=0, enable_n=1, busy=0, frame_done=0, err=0, state=IDLE.
- States: IDLE, BLANK, DWELL.
- IDLE:
  - start=1 with chan_mask!=0: latch mask and dwell; sel <= lowest set bit; go to BLANK (or DWELL if BLANK_CYCLES=0); busy <= 1.
  - start=1 with chan_mask==0: err pulses 1 cycle; remain in IDLE.
- BLANK: enable_n=1 for exactly BLANK_CYCLES cycles; sel is stable; then DWELL.
- DWELL: enable_n=0 for exactly max(dwell_latched,1) cycles. On the last cycle, compute the next channel:
  - Next channel = lowest set latched-mask bit with index > sel.
  - If there is none (wrap): re-latch chan_mask and dwell from the inputs. Next = lowest set bit of the new mask; frame_done=1 in the first cycle of the following BLANK/DWELL.
  - New mask zero at wrap: err pulse, enter IDLE, enable_n=1, busy=0; no frame_done.
- A single-channel mask re-selects the same channel every frame and still blanks between dwells.
- stop=1 in any non-IDLE state: next cycle enable_n=1, busy=0, state=IDLE; sel holds its last value; frame_done is suppressed.
- stop has priority over a simultaneous wrap. start while busy is ignored. Simultaneous start and stop in IDLE: stop wins, remain in IDLE.
- chan_mask and dwell are sampled only at start and at wrap. Mid-frame changes are invisible.
- Reset asserted mid-scan forces reset values immediately (asynchronous).
- Dwell counter is DWELL_W bits; maximum dwell is 2^DWELL_W-1 cycles. No overflow is possible.

Optional Feature:
Macro SCAN_SEQ_ONESHOT_EN.
- Defined: adds input port oneshot (1 bit), sampled with start. If set, the sequencer stops at wrap instead of rescanning: frame_done pulses, state goes to IDLE, enable_n=1, busy=0.
- Undefined: port absent; scanning is always continuous until stop.

Decomposition:
- Package scan_seq_pkg holds:
  - state enum (IDLE, BLANK, DWELL);
  - NUM_CHAN=16;
  - SEL_W=4.
- Sub-module next_chan_find: combinational, given mask[15:0] and cur[3:0], returns next[3:0] and wrap flag. Used twice: first channel (cur forced to wrap search) and next channel. The FSM and counters stay in the top level.

Test Plan:
- Basic scan, BLANK_CYCLES=2, mask=16'h0009, dwell=3, start pulsed at edge 0:
  - cycles 1-2: sel=0, enable_n=1;
  - cycles 3-5: sel=0, enable_n=0;
  - cycles 6-7: sel=3, blank;
  - cycles 8-10: sel=3, active;
  - cycle 11: sel=0, frame_done=1.
- Zero mask: start with mask=0 -> err=1 for one cycle, busy stays 0, enable_n stays 1. Also change mask to 0 mid-frame -> at wrap err=1, IDLE, no frame_done.
- Dwell edge cases:
  - dwell=0 -> 1 active cycle per channel;
  - dwell=8'hFF -> 255 active cycles;
  - mask=16'h8000 -> sel=15 every frame with blanking between dwells.
- Stop mid-DWELL of channel 3: next cycle enable_n=1, busy=0, sel=3; asserting start during busy has no effect.
- Async reset pulse mid-DWELL -> outputs return to reset values with no clock edge required. Scanning restarts only on a new start.
- SCAN_SEQ_ONESHOT_EN defined, oneshot=1, mask=16'h0006 -> channels 1, 2 scanned once, then frame_done=1 and busy=0. With macro undefined, the same stimulus rescans.
